// File: rtl/uart_tx_arb_pkg.sv
// Shared types and default constants for the UART transmit arbiter.
package uart_tx_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitBusy,
        StWaitDone
    } arb_state_e;

    localparam int unsigned DataWidthDefault  = 8;
    localparam int unsigned NumReqDefault     = 4;
    localparam int unsigned TimeoutCycDefault = 8;

    // Width of a requester index; never zero so a single requester still gets one bit.
    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Bundle of requester-side and UART_TX-side signals around the arbiter.
interface uart_tx_arb_if
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DataWidthDefault,
    parameter int unsigned NUM_REQ   = NumReqDefault
);
    localparam int unsigned IdW = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]           REQ;
    logic [NUM_REQ*DATAWIDTH-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]           REQ_PAR_EN;
    logic [NUM_REQ-1:0]           REQ_PAR_TYP;
    logic [NUM_REQ-1:0]           ACK;
    logic [DATAWIDTH-1:0]         P_DATA;
    logic                         PAR_EN;
    logic                         PAR_TYP;
    logic                         DATA_VALID;
    logic                         BUSY;
    logic                         ARB_BUSY;
    logic                         TIMEOUT;
    logic [IdW-1:0]               GNT_ID;

    // Arbiter side.
    modport slave (
        input  REQ, REQ_DATA, REQ_PAR_EN, REQ_PAR_TYP, BUSY,
        output ACK, P_DATA, PAR_EN, PAR_TYP, DATA_VALID, ARB_BUSY, TIMEOUT, GNT_ID
    );

    // Requesters plus UART_TX side.
    modport master (
        output REQ, REQ_DATA, REQ_PAR_EN, REQ_PAR_TYP, BUSY,
        input  ACK, P_DATA, PAR_EN, PAR_TYP, DATA_VALID, ARB_BUSY, TIMEOUT, GNT_ID
    );

endinterface

// File: rtl/uart_tx_arb_rr_arbiter.sv
// Stateless round-robin picker: first active request at or after last_i + 1, wrapping.
module rr_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = NumReqDefault,
    localparam int unsigned IdW    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdW-1:0]     last_i,
    output logic [IdW-1:0]     gnt_o,
    output logic               valid_o
);

    logic [31:0] idx;

    // Walk the requests in rotated order and keep the first hit.
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (32'(last_i) + 32'(i) + 32'd1) % NUM_REQ;
            if (!valid_o && req_i[idx[IdW-1:0]]) begin
                gnt_o   = idx[IdW-1:0];
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one UART_TX among NUM_REQ requesters: round-robin grant, one-cycle
// DATA_VALID/ACK handoff, then waits for UART_TX BUSY to rise and fall.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned DATAWIDTH   = DataWidthDefault,
    parameter int unsigned NUM_REQ     = NumReqDefault,
    parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
    input logic           CLK,
    input logic           RST,
    uart_tx_arb_if.slave  bus
);

    localparam int unsigned IdW  = id_width(NUM_REQ);
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    arb_state_e           state_q;
    logic [IdW-1:0]       last_q;
    logic [CntW-1:0]      cnt_q;
    logic [DATAWIDTH-1:0] p_data_q;
    logic                 par_en_q;
    logic                 par_typ_q;
    logic [IdW-1:0]       gnt_id_q;
    logic                 data_valid_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 arb_busy_q;
    logic                 timeout_q;

    logic [IdW-1:0]       arb_gnt;
    logic                 arb_valid;
    logic [DATAWIDTH-1:0] req_chars [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_chars[g] = bus.REQ_DATA[g*DATAWIDTH +: DATAWIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (bus.REQ),
        .last_i  (last_q),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid)
    );

    // FSM with all outputs, LAST and the timeout counter registered together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            last_q       <= IdW'(NUM_REQ - 1);
            cnt_q        <= '0;
            p_data_q     <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            gnt_id_q     <= '0;
            data_valid_q <= 1'b0;
            ack_q        <= '0;
            arb_busy_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            ack_q        <= '0;
            timeout_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A busy UART_TX blocks any grant, so the winner is chosen late.
                    if (arb_valid && !bus.BUSY) begin
                        state_q      <= StLoad;
                        last_q       <= arb_gnt;
                        gnt_id_q     <= arb_gnt;
                        p_data_q     <= req_chars[arb_gnt];
                        par_en_q     <= bus.REQ_PAR_EN[arb_gnt];
                        par_typ_q    <= bus.REQ_PAR_TYP[arb_gnt];
                        data_valid_q <= 1'b1;
                        ack_q        <= NUM_REQ'(1) << arb_gnt;
                        arb_busy_q   <= 1'b1;
                    end
                end
                StLoad: begin
                    state_q <= StWaitBusy;
                    cnt_q   <= '0;
                end
                StWaitBusy: begin
                    if (bus.BUSY) begin
                        state_q <= StWaitDone;
                    end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                        state_q    <= StIdle;
                        timeout_q  <= 1'b1;
                        arb_busy_q <= 1'b0;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWaitDone: begin
                    if (!bus.BUSY) begin
                        state_q    <= StIdle;
                        arb_busy_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ACK        = ack_q;
    assign bus.P_DATA     = p_data_q;
    assign bus.PAR_EN     = par_en_q;
    assign bus.PAR_TYP    = par_typ_q;
    assign bus.DATA_VALID = data_valid_q;
    assign bus.ARB_BUSY   = arb_busy_q;
    assign bus.TIMEOUT    = timeout_q;
    assign bus.GNT_ID     = gnt_id_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a small UART_TX BUSY model.
module tb_uart_tx_arb;

    logic clk;
    logic rst;
    logic uart_en;
    logic busy_force;
    logic busy_model;
    int   busy_cnt;
    int   n_tests;
    int   n_fail;

    uart_tx_arb_if #(.DATAWIDTH(8), .NUM_REQ(4)) bus ();

    uart_tx_arb #(
        .DATAWIDTH   (8),
        .NUM_REQ     (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    assign bus.BUSY = busy_model | busy_force;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // UART_TX stand-in: BUSY high for three cycles after it sees DATA_VALID.
    initial begin
        busy_model = 1'b0;
        busy_cnt   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_model = 1'b0;
                busy_cnt   = 0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) busy_model = 1'b0;
            end else if (uart_en && bus.DATA_VALID === 1'b1) begin
                busy_model = 1'b1;
                busy_cnt   = 3;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst             = 1'b1;
        bus.REQ         = '0;
        bus.REQ_DATA    = '0;
        bus.REQ_PAR_EN  = '0;
        bus.REQ_PAR_TYP = '0;
        busy_force      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs until ARB_BUSY drops; reports timeout pulses and stray ACKs seen on the way.
    task automatic wait_idle(output bit ok, output bit saw_to, output bit saw_ack);
        ok      = 1'b0;
        saw_to  = 1'b0;
        saw_ack = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.TIMEOUT === 1'b1) saw_to = 1'b1;
            if (bus.ACK !== 4'b0000) saw_ack = 1'b1;
            if (bus.ARB_BUSY === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        uart_en         = 1'b1;
        busy_force      = 1'b0;
        bus.REQ         = '0;
        bus.REQ_DATA    = '0;
        bus.REQ_PAR_EN  = '0;
        bus.REQ_PAR_TYP = '0;
        repeat (2) @(negedge clk);
        n_tests++; if (bus.DATA_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_dv got=%b exp=0", bus.DATA_VALID); end
        n_tests++; if (bus.ACK !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", bus.ACK); end
        n_tests++; if (bus.TIMEOUT !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", bus.TIMEOUT); end
        n_tests++; if (bus.ARB_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_arb_busy got=%b exp=0", bus.ARB_BUSY); end
        n_tests++; if (bus.P_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_p_data got=%h exp=00", bus.P_DATA); end
        n_tests++; if (bus.PAR_EN !== 1'b0 || bus.PAR_TYP !== 1'b0) begin n_fail++; $display("FAIL reset_par got=%b%b exp=00", bus.PAR_EN, bus.PAR_TYP); end
        n_tests++; if (bus.GNT_ID !== 2'd0) begin n_fail++; $display("FAIL reset_gnt_id got=%0d exp=0", bus.GNT_ID); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok, saw_to, saw_ack;
        do_reset();
        uart_en = 1'b1;
        bus.REQ_DATA    = 32'h0000_00A5;
        bus.REQ_PAR_EN  = 4'b0001;
        bus.REQ_PAR_TYP = 4'b0000;
        bus.REQ         = 4'b0001;
        @(negedge clk);
        n_tests++; if (bus.DATA_VALID !== 1'b1) begin n_fail++; $display("FAIL single_dv got=%b exp=1", bus.DATA_VALID); end
        n_tests++; if (bus.ACK !== 4'b0001) begin n_fail++; $display("FAIL single_ack got=%b exp=0001", bus.ACK); end
        n_tests++; if (bus.P_DATA !== 8'hA5) begin n_fail++; $display("FAIL single_p_data got=%h exp=a5", bus.P_DATA); end
        n_tests++; if (bus.PAR_EN !== 1'b1 || bus.PAR_TYP !== 1'b0) begin n_fail++; $display("FAIL single_par got=%b%b exp=10", bus.PAR_EN, bus.PAR_TYP); end
        n_tests++; if (bus.ARB_BUSY !== 1'b1) begin n_fail++; $display("FAIL single_arb_busy got=%b exp=1", bus.ARB_BUSY); end
        bus.REQ = 4'b0000;
        @(negedge clk);
        n_tests++; if (bus.DATA_VALID !== 1'b0 || bus.ACK !== 4'b0000) begin n_fail++; $display("FAIL single_pulse_len dv=%b ack=%b exp dv=0 ack=0000", bus.DATA_VALID, bus.ACK); end
        wait_idle(ok, saw_to, saw_ack);
        n_tests++; if (!ok || saw_to) begin n_fail++; $display("FAIL single_return_idle idle=%b timeout=%b exp idle=1 timeout=0", ok, saw_to); end
        n_tests++; if (bus.P_DATA !== 8'hA5) begin n_fail++; $display("FAIL single_p_data_hold got=%h exp=a5", bus.P_DATA); end
    endtask

    task automatic test_round_robin();
        bit ok, saw_to, saw_ack;
        int exp_order [5];
        logic [7:0] chars [4];
        logic [3:0] pe;
        logic [3:0] pt;
        int ngr;
        exp_order = '{0, 1, 2, 3, 0};
        chars     = '{8'h11, 8'h22, 8'h33, 8'h44};
        pe        = 4'b1010;
        pt        = 4'b0110;
        do_reset();
        uart_en = 1'b1;
        bus.REQ_DATA    = 32'h4433_2211;
        bus.REQ_PAR_EN  = pe;
        bus.REQ_PAR_TYP = pt;
        bus.REQ         = 4'b1111;
        ngr = 0;
        for (int cyc = 0; cyc < 200 && ngr < 5; cyc++) begin
            @(negedge clk);
            if (bus.ACK !== 4'b0000) begin
                n_tests++; if (bus.ACK !== (4'b0001 << exp_order[ngr])) begin n_fail++; $display("FAIL rr_ack[%0d] got=%b exp_idx=%0d", ngr, bus.ACK, exp_order[ngr]); end
                n_tests++; if (bus.GNT_ID !== 2'(exp_order[ngr])) begin n_fail++; $display("FAIL rr_gnt_id[%0d] got=%0d exp=%0d", ngr, bus.GNT_ID, exp_order[ngr]); end
                n_tests++; if (bus.P_DATA !== chars[exp_order[ngr]] || bus.DATA_VALID !== 1'b1) begin n_fail++; $display("FAIL rr_data[%0d] got=%h dv=%b exp=%h dv=1", ngr, bus.P_DATA, bus.DATA_VALID, chars[exp_order[ngr]]); end
                n_tests++; if (bus.PAR_EN !== pe[exp_order[ngr]] || bus.PAR_TYP !== pt[exp_order[ngr]]) begin n_fail++; $display("FAIL rr_par[%0d] got=%b%b exp=%b%b", ngr, bus.PAR_EN, bus.PAR_TYP, pe[exp_order[ngr]], pt[exp_order[ngr]]); end
                ngr++;
                if (ngr == 5) bus.REQ = 4'b0000;
            end
        end
        n_tests++; if (ngr != 5) begin n_fail++; $display("FAIL rr_grant_count got=%0d exp=5", ngr); end
        wait_idle(ok, saw_to, saw_ack);
        n_tests++; if (!ok || saw_to || saw_ack) begin n_fail++; $display("FAIL rr_drain idle=%b timeout=%b ack=%b exp 1 0 0", ok, saw_to, saw_ack); end
    endtask

    task automatic test_timeout();
        bit found;
        logic exp_to;
        logic exp_busy;
        do_reset();
        uart_en = 1'b0;
        bus.REQ_DATA = 32'h0077_0000;
        bus.REQ      = 4'b0100;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.DATA_VALID === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++; if (!found || bus.ACK !== 4'b0100 || bus.GNT_ID !== 2'd2) begin n_fail++; $display("FAIL to_grant found=%b ack=%b gnt=%0d exp 1 0100 2", found, bus.ACK, bus.GNT_ID); end
        bus.REQ = 4'b0000;
        // WAIT_BUSY is entered one edge after LOAD; the pulse lands eight cycles later.
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp_to   = (k == 9);
            exp_busy = (k < 9);
            n_tests++; if (bus.TIMEOUT !== exp_to) begin n_fail++; $display("FAIL to_pulse[k=%0d] got=%b exp=%b", k, bus.TIMEOUT, exp_to); end
            n_tests++; if (bus.ARB_BUSY !== exp_busy) begin n_fail++; $display("FAIL to_arb_busy[k=%0d] got=%b exp=%b", k, bus.ARB_BUSY, exp_busy); end
        end
        uart_en = 1'b1;
    endtask

    task automatic test_busy_block();
        bit ok, saw_to, saw_ack;
        do_reset();
        uart_en      = 1'b1;
        busy_force   = 1'b1;
        bus.REQ_DATA = 32'h0000_5A00;
        bus.REQ      = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++; if (bus.DATA_VALID !== 1'b0 || bus.ACK !== 4'b0000 || bus.ARB_BUSY !== 1'b0) begin n_fail++; $display("FAIL busy_block[%0d] dv=%b ack=%b arb=%b exp 0 0000 0", i, bus.DATA_VALID, bus.ACK, bus.ARB_BUSY); end
        end
        busy_force = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.DATA_VALID !== 1'b1 || bus.ACK !== 4'b0010 || bus.GNT_ID !== 2'd1) begin n_fail++; $display("FAIL busy_release dv=%b ack=%b gnt=%0d exp 1 0010 1", bus.DATA_VALID, bus.ACK, bus.GNT_ID); end
        n_tests++; if (bus.P_DATA !== 8'h5A) begin n_fail++; $display("FAIL busy_release_data got=%h exp=5a", bus.P_DATA); end
        bus.REQ = 4'b0000;
        wait_idle(ok, saw_to, saw_ack);
        n_tests++; if (!ok || saw_to) begin n_fail++; $display("FAIL busy_drain idle=%b timeout=%b exp 1 0", ok, saw_to); end
    endtask

    task automatic test_skip();
        bit ok, saw_to, saw_ack;
        do_reset();
        uart_en      = 1'b1;
        busy_force   = 1'b1;
        bus.REQ_DATA = 32'h00C3_00E1;
        bus.REQ      = 4'b0001;
        @(negedge clk);
        bus.REQ = 4'b0100;
        @(negedge clk);
        busy_force = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.ACK !== 4'b0100 || bus.GNT_ID !== 2'd2 || bus.P_DATA !== 8'hC3) begin n_fail++; $display("FAIL skip_grant ack=%b gnt=%0d data=%h exp 0100 2 c3", bus.ACK, bus.GNT_ID, bus.P_DATA); end
        bus.REQ = 4'b0000;
        wait_idle(ok, saw_to, saw_ack);
        n_tests++; if (!ok || saw_ack) begin n_fail++; $display("FAIL skip_no_extra idle=%b ack=%b exp 1 0", ok, saw_ack); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok, saw_to, saw_ack;
        do_reset();
        uart_en         = 1'b1;
        bus.REQ_DATA    = 32'h0096_0069;
        bus.REQ_PAR_EN  = 4'b0100;
        bus.REQ_PAR_TYP = 4'b0100;
        bus.REQ         = 4'b0100;
        @(negedge clk);
        n_tests++; if (bus.ACK !== 4'b0100) begin n_fail++; $display("FAIL mid_first_ack got=%b exp=0100", bus.ACK); end
        bus.REQ = 4'b0000;
        repeat (2) @(negedge clk);
        n_tests++; if (bus.ARB_BUSY !== 1'b1 || bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL mid_in_wait_done arb=%b busy=%b exp 1 1", bus.ARB_BUSY, bus.BUSY); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (bus.DATA_VALID !== 1'b0 || bus.ACK !== 4'b0000 || bus.TIMEOUT !== 1'b0 || bus.ARB_BUSY !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctrl dv=%b ack=%b to=%b arb=%b exp all 0", bus.DATA_VALID, bus.ACK, bus.TIMEOUT, bus.ARB_BUSY); end
        n_tests++; if (bus.P_DATA !== 8'h00 || bus.PAR_EN !== 1'b0 || bus.PAR_TYP !== 1'b0 || bus.GNT_ID !== 2'd0) begin n_fail++; $display("FAIL mid_rst_data data=%h pe=%b pt=%b gnt=%0d exp all 0", bus.P_DATA, bus.PAR_EN, bus.PAR_TYP, bus.GNT_ID); end
        bus.REQ = 4'b0101;
        @(negedge clk);
        n_tests++; if (bus.ACK !== 4'b0001 || bus.GNT_ID !== 2'd0 || bus.P_DATA !== 8'h69) begin n_fail++; $display("FAIL mid_next_grant ack=%b gnt=%0d data=%h exp 0001 0 69", bus.ACK, bus.GNT_ID, bus.P_DATA); end
        bus.REQ = 4'b0000;
        wait_idle(ok, saw_to, saw_ack);
        n_tests++; if (!ok || saw_to) begin n_fail++; $display("FAIL mid_drain idle=%b timeout=%b exp 1 0", ok, saw_to); end
    endtask

    task automatic test_data_change();
        bit found;
        bit ok;
        do_reset();
        uart_en      = 1'b1;
        bus.REQ_DATA = 32'h0000_3C00;
        bus.REQ      = 4'b0010;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ACK !== 4'b0000) begin
                found = 1'b1;
                break;
            end
        end
        n_tests++; if (!found || bus.ACK !== 4'b0010 || bus.P_DATA !== 8'h3C) begin n_fail++; $display("FAIL chg_grant found=%b ack=%b data=%h exp 1 0010 3c", found, bus.ACK, bus.P_DATA); end
        bus.REQ = 4'b0000;
        @(negedge clk);
        bus.REQ_DATA = 32'h0000_FF00;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++; if (bus.P_DATA !== 8'h3C) begin n_fail++; $display("FAIL chg_hold[%0d] got=%h exp=3c", i, bus.P_DATA); end
            if (bus.ARB_BUSY === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL chg_drain idle=%b exp=1", ok); end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        uart_en    = 1'b1;
        busy_force = 1'b0;
        rst        = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_busy_block();
        test_skip();
        test_reset_mid_frame();
        test_data_change();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, meaning the character width forwarded to UART_TX.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one UART_TX.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 8, meaning the maximum number of cycles to wait for BUSY after issuing DATA_VALID.
REQ-004 The block SHALL use one clock, CLK; reset SHALL be RST, synchronous and active-high.
REQ-005 The block SHALL have the following ports:
  - CLK  in  1  system clock
  - RST  in  1  synchronous active-high reset
  - REQ  in  NUM_REQ  per-requester send request; level, held until ACK
  - REQ_DATA  in  NUM_REQ*DATAWIDTH  packed characters; requester i occupies slice [i*DATAWIDTH +: DATAWIDTH]
  - REQ_PAR_EN  in  NUM_REQ  per-requester parity enable
  - REQ_PAR_TYP  in  NUM_REQ  per-requester parity type
  - ACK  out  NUM_REQ  one-hot, one-cycle pulse: the character has been handed to UART_TX
  - P_DATA  out  DATAWIDTH  to UART_TX
  - PAR_EN  out  1  to UART_TX
  - PAR_TYP  out  1  to UART_TX
  - DATA_VALID  out  1  to UART_TX
  - BUSY  in  1  from UART_TX
  - ARB_BUSY  out  1  high whenever the state is not IDLE
  - TIMEOUT  out  1  one-cycle pulse: UART_TX never raised BUSY
  - GNT_ID  out  clog2(NUM_REQ)  index of the current/last granted requester

Function
REQ-006 The FSM SHALL have four states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-007 IDLE -> LOAD SHALL occur when |REQ and BUSY=0; with BUSY=1 the block SHALL stay in IDLE and grant nothing.
REQ-008 The arbitration SHALL be round-robin: search starts at (LAST+1) mod NUM_REQ, where LAST is the index of the previous grant.
REQ-009 On the IDLE->LOAD edge, the block SHALL register P_DATA, PAR_EN, PAR_TYP and GNT_ID from the winner; these SHALL stay stable until the next grant.
REQ-010 In LOAD, DATA_VALID=1 and ACK[GNT_ID]=1 for exactly one cycle; LOAD -> WAIT_BUSY unconditionally.
REQ-011 In WAIT_BUSY, BUSY=1 SHALL cause WAIT_BUSY -> WAIT_DONE; otherwise a counter SHALL increment.
REQ-012 When the WAIT_BUSY counter reaches TIMEOUT_CYC, the block SHALL pulse TIMEOUT for one cycle and go to IDLE.
REQ-013 In WAIT_DONE, BUSY=0 SHALL cause WAIT_DONE -> IDLE.
REQ-014 A new grant SHALL NOT occur earlier than the cycle after the return to IDLE, giving a minimum IDLE dwell of one cycle.
REQ-015 A requester that deasserts REQ before it is granted SHALL be skipped without side effects.
REQ-016 REQ changes after ACK SHALL NOT affect the frame in flight.
REQ-017 Simultaneous requests SHALL yield exactly one ACK per grant; ACK SHALL never have more than one bit set.
REQ-018 All outputs SHALL be registered.

Reset
REQ-019 While RST=1 at a CLK edge, the block SHALL go to IDLE with DATA_VALID=0, ACK=0, TIMEOUT=0, ARB_BUSY=0, P_DATA=0, PAR_EN=0, PAR_TYP=0, GNT_ID=0, counter=0, and LAST=NUM_REQ-1 so requester 0 has first priority.
REQ-020 Reset asserted mid-frame SHALL abort the frame; no ACK or TIMEOUT SHALL be generated for it.

Structure
REQ-021 Package uart_tx_arb_pkg SHALL hold the state enum and the default constants for NUM_REQ and TIMEOUT_CYC.
REQ-022 The round-robin picker SHALL be a sub-module rr_arbiter (inputs: request vector, LAST; outputs: grant index, valid); it SHALL be combinational and contain no state.
REQ-023 The top level SHALL contain the FSM, the LAST register, the output registers and the timeout counter.

Verification
REQ-024 Reset, then REQ=0001, REQ_DATA[7:0]=0xA5, PAR_EN=1, PAR_TYP=0 -> LOAD 1 cycle after the request: P_DATA=0xA5, DATA_VALID=1, ACK=0001 for one cycle; return to IDLE after the UART_TX BUSY pulse.
REQ-025 REQ=1111 held continuously with UART_TX attached -> grant order 0,1,2,3,0; GNT_ID follows that sequence; one ACK per frame.
REQ-026 UART_TX model with BUSY tied low -> TIMEOUT pulses exactly TIMEOUT_CYC(=8) cycles after the WAIT_BUSY entry; the state returns to IDLE.
REQ-027 BUSY=1 externally while REQ=0010 -> no DATA_VALID until BUSY=0, then a grant to requester 1.
REQ-028 RST pulsed during WAIT_DONE -> next cycle: IDLE, all outputs 0; the next grant goes to requester 0.
REQ-029 Change REQ_DATA[15:8] from 0x3C to 0xFF one cycle after ACK[1] -> P_DATA stays 0x3C through WAIT_DONE.
